// File: rtl/otter_mem_port2_arbiter.sv
// otter_mem_port2_arbiter: shares OTTER memory port 2 between the CPU memory stage and a DMA/loader,
// sequencing one-cycle writes and two-cycle reads with address/size/sign held through the return cycle.
module otter_mem_port2_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [31:0] IO_BASE      = 32'h11000000
) (
   input  logic        MEM_CLK,
   input  logic        MEM_RST_N,
   input  logic        CPU_REQ,
   input  logic        CPU_WE,
   input  logic [31:0] CPU_ADDR,
   input  logic [31:0] CPU_DIN,
   input  logic [1:0]  CPU_SIZE,
   input  logic        CPU_SIGN,
   output logic        CPU_GNT,
   output logic        CPU_RVALID,
   output logic [31:0] CPU_RDATA,
   input  logic        DMA_REQ,
   input  logic        DMA_WE,
   input  logic [31:0] DMA_ADDR,
   input  logic [31:0] DMA_DIN,
   input  logic [1:0]  DMA_SIZE,
   input  logic        DMA_SIGN,
   output logic        DMA_GNT,
   output logic        DMA_RVALID,
   output logic [31:0] DMA_RDATA,
   output logic        DMA_ERR,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);
   typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   state_t      state_q;
   logic [3:0]  starve_q;
   logic [31:0] addr_q, cpu_rdata_q, dma_rdata_q;
   logic [1:0]  size_q;
   logic        sign_q, cpu_rvalid_q, dma_rvalid_q;
   logic        idle, held, dma_win, sel_dma, cpu_gnt, dma_gnt, dma_io, cpu_rd, dma_rd;
   always_comb begin
      held    = state_q != IDLE;
      idle    = !held && MEM_RST_N;
      dma_win = DMA_REQ && (!CPU_REQ || starve_q == LIMIT);
      cpu_gnt = idle && CPU_REQ && !dma_win;
      dma_gnt = idle && dma_win;
      dma_io  = DMA_ADDR >= IO_BASE;
      cpu_rd  = cpu_gnt && !CPU_WE;
      dma_rd  = dma_gnt && !DMA_WE && !dma_io;
      sel_dma = !held && dma_win;
   end
   // During a read-return cycle the memory's sliced output still depends on these, so they stay frozen
   always_comb begin
      MEM_ADDR2  = held ? addr_q : sel_dma ? DMA_ADDR : CPU_ADDR;
      MEM_SIZE   = held ? size_q : sel_dma ? DMA_SIZE : CPU_SIZE;
      MEM_SIGN   = held ? sign_q : sel_dma ? DMA_SIGN : CPU_SIGN;
      MEM_DIN2   = sel_dma ? DMA_DIN : CPU_DIN;
      MEM_WRITE2 = (cpu_gnt && CPU_WE) || (dma_gnt && DMA_WE && !dma_io);
      MEM_READ2  = cpu_rd || dma_rd;
   end
   assign CPU_GNT    = cpu_gnt;
   assign DMA_GNT    = dma_gnt;
   assign DMA_ERR    = dma_gnt && dma_io;
   assign CPU_RVALID = cpu_rvalid_q;
   assign DMA_RVALID = dma_rvalid_q;
   assign CPU_RDATA  = cpu_rdata_q;
   assign DMA_RDATA  = dma_rdata_q;
   always_ff @(posedge MEM_CLK) begin
      if (!MEM_RST_N) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         addr_q       <= '0;
         size_q       <= '0;
         sign_q       <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         cpu_rvalid_q <= state_q == CPU_RD;
         dma_rvalid_q <= state_q == DMA_RD;
         if (state_q == CPU_RD) cpu_rdata_q <= MEM_DOUT2;
         if (state_q == DMA_RD) dma_rdata_q <= MEM_DOUT2;
         if (held) state_q <= IDLE;
         else begin
            state_q  <= cpu_rd ? CPU_RD : dma_rd ? DMA_RD : IDLE;
            starve_q <= (dma_gnt || !DMA_REQ) ? '0 :
                        (cpu_gnt && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
            if (cpu_rd || dma_rd) begin
               addr_q <= MEM_ADDR2;
               size_q <= MEM_SIZE;
               sign_q <= MEM_SIGN;
            end
         end
      end
   end
endmodule

// File: tb/tb_otter_mem_port2_arbiter.sv
// tb_otter_mem_port2_arbiter: directed plus randomized two-requester traffic against a byte-array
// memory; a per-cycle reference model predicts grants and read results into per-owner scoreboards.
module tb_otter_mem_port2_arbiter;
   localparam int unsigned STARVE_LIMIT = 4;
   localparam logic [31:0] IO_BASE = 32'h11000000;
   logic        clk = 0, rst_n = 0;
   logic        cpu_req = 0, cpu_we = 0, cpu_sign = 0, dma_req = 0, dma_we = 0, dma_sign = 0;
   logic [31:0] cpu_addr = 0, cpu_din = 0, dma_addr = 0, dma_din = 0;
   logic [1:0]  cpu_size = 0, dma_size = 0;
   logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_err, mem_write2, mem_read2, mem_sign;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr2, mem_din2, mem_dout;
   logic [1:0]  mem_size;
   int tests = 0, fails = 0, cyc = 0;
   typedef struct {int due; logic [31:0] data;} exp_t;
   exp_t cq[$], dq[$];
   logic [7:0] env_mem [1024];
   logic [7:0] ref_mem [1024];

   otter_mem_port2_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .IO_BASE(IO_BASE)) dut (
      .MEM_CLK(clk), .MEM_RST_N(rst_n),
      .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din),
      .CPU_SIZE(cpu_size), .CPU_SIGN(cpu_sign), .CPU_GNT(cpu_gnt), .CPU_RVALID(cpu_rvalid),
      .CPU_RDATA(cpu_rdata),
      .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr), .DMA_DIN(dma_din),
      .DMA_SIZE(dma_size), .DMA_SIGN(dma_sign), .DMA_GNT(dma_gnt), .DMA_RVALID(dma_rvalid),
      .DMA_RDATA(dma_rdata), .DMA_ERR(dma_err),
      .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2), .MEM_WRITE2(mem_write2), .MEM_READ2(mem_read2),
      .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ix(input logic [31:0] a, input int k);
      return int'((a + 32'(k)) & 32'h3FF);
   endfunction
   // little-endian byte/half/word load; sg=1 means zero-extend
   function automatic logic [31:0] ext(input logic [7:0] b0, b1, b2, b3, input logic [1:0] sz, input logic sg);
      if (sz == 2'd0) return sg ? {24'h0, b0} : {{24{b0[7]}}, b0};
      if (sz == 2'd1) return sg ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      return {b3, b2, b1, b0};
   endfunction
   function automatic logic [31:0] rnd_addr(input logic [1:0] sz);
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? IO_BASE + ($urandom & 32'h3FF) : ($urandom & 32'h3FF);
      return a & ~((32'd1 << sz) - 32'd1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   // memory attached to port 2
   always_comb mem_dout = ext(env_mem[ix(mem_addr2, 0)], env_mem[ix(mem_addr2, 1)],
                              env_mem[ix(mem_addr2, 2)], env_mem[ix(mem_addr2, 3)], mem_size, mem_sign);
   always @(posedge clk) if (mem_write2) begin
      env_mem[ix(mem_addr2, 0)] = mem_din2[7:0];
      if (mem_size != 2'd0) env_mem[ix(mem_addr2, 1)] = mem_din2[15:8];
      if (mem_size == 2'd2) begin
         env_mem[ix(mem_addr2, 2)] = mem_din2[23:16];
         env_mem[ix(mem_addr2, 3)] = mem_din2[31:24];
      end
   end

   // reference model: predicts each cycle's grants from the arbitration rules
   int m_starve = 0;
   bit m_busy = 0, m_rst_prev = 0;
   logic [31:0] h_addr;
   logic [1:0]  h_size;
   logic        h_sign;
   always @(negedge clk) if (cyc > 0) begin
      bit cg, dg, io, we;
      logic [31:0] a, d;
      logic [1:0] sz;
      logic sg;
      if (m_rst_prev) begin
         chk("reset_cpu_rdata", cpu_rdata, 0);
         chk("reset_dma_rdata", dma_rdata, 0);
         chk("reset_rvalids", {cpu_rvalid, dma_rvalid}, 0);
      end
      cg = 0; dg = 0;
      if (rst_n && !m_busy) begin
         if (dma_req && (!cpu_req || m_starve == int'(STARVE_LIMIT))) dg = 1;
         else if (cpu_req) cg = 1;
      end
      io = dma_addr >= IO_BASE;
      we = dg ? dma_we : cpu_we;
      a = dg ? dma_addr : cpu_addr;
      d = dg ? dma_din : cpu_din;
      sz = dg ? dma_size : cpu_size;
      sg = dg ? dma_sign : cpu_sign;
      chk("gnt", {cpu_gnt, dma_gnt}, {cg, dg});
      chk("dma_err", dma_err, dg && io);
      chk("mem_write2", mem_write2, (cg || (dg && !io)) && we);
      chk("mem_read2", mem_read2, (cg || (dg && !io)) && !we);
      if (cg || dg) begin
         chk("grant_addr", mem_addr2, a);
         chk("grant_size_sign", {mem_size, mem_sign}, {sz, sg});
         if (we) chk("grant_din", mem_din2, d);
      end
      if (m_busy) chk("held_addr_size_sign", {mem_addr2, mem_size, mem_sign}, {h_addr, h_size, h_sign});
      if (!rst_n) begin
         m_busy = 0; m_starve = 0;
         cq.delete(); dq.delete();
      end else if (m_busy) m_busy = 0;
      else begin
         if (dg || !dma_req) m_starve = 0;
         else if (cg) m_starve++;
         if ((cg || dg) && !(dg && io)) begin
            if (we) begin
               ref_mem[ix(a, 0)] = d[7:0];
               if (sz != 2'd0) ref_mem[ix(a, 1)] = d[15:8];
               if (sz == 2'd2) begin
                  ref_mem[ix(a, 2)] = d[23:16];
                  ref_mem[ix(a, 3)] = d[31:24];
               end
            end else begin
               exp_t e;
               e.due = cyc + 2;
               e.data = ext(ref_mem[ix(a, 0)], ref_mem[ix(a, 1)], ref_mem[ix(a, 2)], ref_mem[ix(a, 3)], sz, sg);
               if (cg) cq.push_back(e); else dq.push_back(e);
               m_busy = 1; h_addr = a; h_size = sz; h_sign = sg;
            end
         end
      end
      m_rst_prev = !rst_n;
   end

   // monitor: pops the scoreboard whenever a read return appears
   always @(negedge clk) if (cyc > 0) begin
      exp_t e;
      if (cpu_rvalid) begin
         if (cq.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
         else begin
            e = cq.pop_front();
            chk("cpu_rvalid_cycle", cyc, e.due);
            chk("cpu_rdata", cpu_rdata, e.data);
         end
      end else if (cq.size() != 0 && cq[0].due < cyc) begin
         e = cq.pop_front();
         chk("cpu_rvalid_missing", 0, 1);
      end
      if (dma_rvalid) begin
         if (dq.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
         else begin
            e = dq.pop_front();
            chk("dma_rvalid_cycle", cyc, e.due);
            chk("dma_rdata", dma_rdata, e.data);
         end
      end else if (dq.size() != 0 && dq[0].due < cyc) begin
         e = dq.pop_front();
         chk("dma_rvalid_missing", 0, 1);
      end
   end

   task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic sg);
      cpu_we = we; cpu_addr = a; cpu_din = d; cpu_size = sz; cpu_sign = sg; cpu_req = 1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (cpu_gnt) break;
      end
      if (!cpu_gnt) chk("cpu_grant_timeout", 0, 1);
      @(posedge clk); #1 cpu_req = 0;
   endtask
   task automatic dma_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic sg);
      dma_we = we; dma_addr = a; dma_din = d; dma_size = sz; dma_sign = sg; dma_req = 1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (dma_gnt) break;
      end
      if (!dma_gnt) chk("dma_grant_timeout", 0, 1);
      @(posedge clk); #1 dma_req = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin env_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
      {env_mem[256], env_mem[257], env_mem[258], env_mem[259]} = 32'hEFBEADDE;
      {ref_mem[256], ref_mem[257], ref_mem[258], ref_mem[259]} = 32'hEFBEADDE;
      fork
         cpu_op(0, 32'h100, 0, 2'd2, 0);
         dma_op(1, 32'h40, 32'h5A5A1234, 2'd2, 0);
      join_none
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      wait fork;
      dma_op(1, 32'h203, 32'h000000A5, 2'd0, 0);
      dma_op(0, 32'h203, 0, 2'd0, 1);
      fork
         for (int k = 0; k < 6; k++) cpu_op(1, 32'h80 + 32'(4 * k), 32'h1000 + 32'(k), 2'd2, 0);
         dma_op(1, 32'h300, 32'hCAFEF00D, 2'd2, 0);
         begin
            int n = 0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (dma_gnt) break;
               if (cpu_gnt) n++;
            end
            chk("starve_cpu_grants_before_dma", n, STARVE_LIMIT);
         end
      join
      dma_op(1, IO_BASE, 32'h12345678, 2'd2, 0);
      cpu_op(1, IO_BASE, 32'h87654321, 2'd2, 0);
      cpu_op(0, 32'h100, 0, 2'd2, 0);
      repeat (3) @(posedge clk);
      #1;
      cpu_op(0, 32'h100, 0, 2'd1, 1);
      rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      fork
         for (int k = 0; k < 150; k++) begin
            logic [1:0] sz = 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            cpu_op(1'($urandom), rnd_addr(sz), $urandom, sz, 1'($urandom));
         end
         for (int k = 0; k < 150; k++) begin
            logic [1:0] sz = 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            dma_op(1'($urandom), rnd_addr(sz), $urandom, sz, 1'($urandom));
         end
      join
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", cq.size() + dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end
endmodule
